// File: rtl/fft_addr_if.sv
// fft_addr_if: controller-side start/stall and bank address/strobe bundle of the FFT address sequencer
interface fft_addr_if #(parameter int AW = 3);
  logic          start;
  logic          stall;
  logic [3:0]    stage_num;
  logic [AW-1:0] r_addr_0_1;
  logic [AW-1:0] r_addr_2_3;
  logic [AW-1:0] w_addr_0_1;
  logic [AW-1:0] w_addr_2_3;
  logic          rd_en;
  logic          wr_en;
  logic          busy;
  logic          done;
  modport master (
    output start, stall,
    input  stage_num, r_addr_0_1, r_addr_2_3, w_addr_0_1, w_addr_2_3, rd_en, wr_en, busy, done
  );
  modport slave (
    input  start, stall,
    output stage_num, r_addr_0_1, r_addr_2_3, w_addr_0_1, w_addr_2_3, rd_en, wr_en, busy, done
  );
endinterface

// File: rtl/fft_addr_sequencer.sv
// fft_addr_sequencer: self-timed radix-2 FFT bank address sequencer; FFT_ADDR_UNLOAD_EN adds a bit-reversed unload pass
module fft_addr_sequencer #(
  parameter int LOG2N  = 5,
  parameter int BF_LAT = 2
) (
  input logic     clk,
  input logic     rst_n,
  fft_addr_if.slave bus
);
  localparam int AW = LOG2N - 2;
`ifdef FFT_ADDR_UNLOAD_EN
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, UNLOAD, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} state_t;
`endif
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [3:0]    stage_q, stage_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic          unl_d, rd_d, busy_d, hold;
  logic [AW-1:0] ra01_d, ra23_d;
  logic          vld_q [BF_LAT];
  logic [AW-1:0] a01_q [BF_LAT];
  logic [AW-1:0] a23_q [BF_LAT];

  function automatic logic [AW-1:0] mask_f(input logic [3:0] s);
    mask_f = ~({AW{1'b1}} >> ((int'(s) > AW) ? AW : int'(s)));
  endfunction

  // next position of the stage/sample walk; only committed on un-stalled edges
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        cnt_d   = '0;
        stage_d = '0;
      end
      RUN: if (&cnt_q) begin
        state_d = DRAIN;
        dcnt_d  = '0;
      end else cnt_d = cnt_q + AW'(1);
      DRAIN: begin
        if (dcnt_q != 4'(BF_LAT - 1)) dcnt_d = dcnt_q + 4'd1;
        else if (stage_q != 4'(LOG2N - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
          stage_d = stage_q + 4'd1;
        end
`ifdef FFT_ADDR_UNLOAD_EN
        else begin
          state_d = UNLOAD;
          cnt_d   = '0;
          stage_d = 4'(LOG2N);
        end
      end
      UNLOAD: if (&cnt_q) state_d = DONE;
      else cnt_d = cnt_q + AW'(1);
`else
        else state_d = DONE;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef FFT_ADDR_UNLOAD_EN
  function automatic logic [AW-1:0] bitrev_f(input logic [AW-1:0] c);
    for (int i = 0; i < AW; i++) bitrev_f[i] = c[AW-1-i];
  endfunction
  assign unl_d  = state_d == UNLOAD;
  assign ra01_d = unl_d ? bitrev_f(cnt_d) : cnt_d;
  assign ra23_d = unl_d ? bitrev_f(cnt_d) : cnt_d ^ mask_f(stage_d);
`else
  assign unl_d  = 1'b0;
  assign ra01_d = cnt_d;
  assign ra23_d = cnt_d ^ mask_f(stage_d);
`endif
  assign rd_d   = state_d == RUN || unl_d;
  assign busy_d = rd_d || state_d == DRAIN;
  // busy mirrors an active state, so stall only bites while a transform is in flight
  assign hold   = bus.stall && bus.busy;

  // state, registered outputs and the read-to-write delay line; a stall freezes all but the strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stage_q        <= '0;
      dcnt_q         <= '0;
      bus.stage_num  <= '0;
      bus.r_addr_0_1 <= '0;
      bus.r_addr_2_3 <= '0;
      bus.w_addr_0_1 <= '0;
      bus.w_addr_2_3 <= '0;
      bus.rd_en      <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      for (int i = 0; i < BF_LAT; i++) begin
        vld_q[i] <= 1'b0;
        a01_q[i] <= '0;
        a23_q[i] <= '0;
      end
    end else if (hold) begin
      bus.rd_en <= 1'b0;
      bus.wr_en <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stage_q       <= stage_d;
      dcnt_q        <= dcnt_d;
      bus.stage_num <= stage_d;
      bus.rd_en     <= rd_d;
      bus.busy      <= busy_d;
      bus.done      <= state_d == DONE;
      if (rd_d) begin
        bus.r_addr_0_1 <= ra01_d;
        bus.r_addr_2_3 <= ra23_d;
      end
      vld_q[0] <= rd_d && !unl_d;
      a01_q[0] <= ra01_d;
      a23_q[0] <= ra23_d;
      for (int i = 1; i < BF_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        a01_q[i] <= a01_q[i-1];
        a23_q[i] <= a23_q[i-1];
      end
      bus.wr_en <= vld_q[BF_LAT-1];
      if (vld_q[BF_LAT-1]) begin
        bus.w_addr_0_1 <= a01_q[BF_LAT-1];
        bus.w_addr_2_3 <= a23_q[BF_LAT-1];
      end
    end
endmodule

// File: tb/tb_fft_addr_sequencer.sv
// tb_fft_addr_sequencer: randomized scoreboard bench for fft_addr_sequencer
module tb_fft_addr_sequencer;
  localparam int LOG2N  = 5;
  localparam int BF_LAT = 2;
  localparam int AW     = LOG2N - 2;
  localparam int N      = 1 << AW;
`ifdef FFT_ADDR_UNLOAD_EN
  localparam int BASE = LOG2N * (N + BF_LAT) + N;
`else
  localparam int BASE = LOG2N * (N + BF_LAT);
`endif
  typedef struct packed {
    logic [3:0]    st;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  xfer_t rq[$];
  xfer_t wq[$];
  int tq[$];
  int compared = 0;
  int mismatched = 0;
  int tick = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int exp_busy = 0;
  logic stl = 1'b0;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  fft_addr_if #(.AW(AW)) bus();
  fft_addr_sequencer #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference: every stage reads 0..N-1 on banks 0/1 and cnt^mask on banks 2/3, writes mirror the reads
  task automatic push_model();
    int m;
    int br;
    for (int s = 0; s < LOG2N; s++) begin
      m = 0;
      for (int k = 0; k < s && k < AW; k++) m += 1 << (AW - 1 - k);
      for (int c = 0; c < N; c++) begin
        rq.push_back('{4'(s), AW'(c), AW'(c ^ m)});
        wq.push_back('{4'(s), AW'(c), AW'(c ^ m)});
      end
    end
`ifdef FFT_ADDR_UNLOAD_EN
    for (int c = 0; c < N; c++) begin
      br = 0;
      for (int k = 0; k < AW; k++) if (((c >> k) & 1) == 1) br += 1 << (AW - 1 - k);
      rq.push_back('{4'(LOG2N), AW'(br), AW'(br)});
    end
`endif
  endtask

  always @(posedge clk) begin
    stl <= bus.stall && bus.busy;
    if (!(bus.stall && bus.busy)) tick <= tick + 1;
  end

  always @(negedge clk) begin : mon
    xfer_t e;
    if (rst_n) begin
      if (stl) chk("stall_gap", {bus.rd_en, bus.wr_en}, 0);
      if (bus.rd_en) begin
        if (rq.size() == 0) chk("rd_extra", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rd_stage", bus.stage_num, e.st);
          chk("r_addr_0_1", bus.r_addr_0_1, e.a);
          chk("r_addr_2_3", bus.r_addr_2_3, e.b);
          if (int'(e.st) < LOG2N) tq.push_back(tick);
        end
      end
      if (bus.wr_en) begin
        if (wq.size() == 0 || tq.size() == 0) chk("wr_extra", 1, 0);
        else begin
          e = wq.pop_front();
          chk("w_addr_0_1", bus.w_addr_0_1, e.a);
          chk("w_addr_2_3", bus.w_addr_2_3, e.b);
          chk("wr_latency", tick - tq.pop_front(), BF_LAT);
        end
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        chk("done_busy", bus.busy, 0);
        chk("done_pulse", done_prev, 0);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("rd_left", rq.size(), 0);
        chk("wr_left", wq.size(), 0);
        busy_cnt = 0;
      end
      done_prev = bus.done;
    end
  end

  task automatic do_run(input int pct, input bit extra, input bit st_start);
    int d0;
    d0 = done_cnt;
    exp_busy = BASE;
    push_model();
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.stall = st_start;
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    for (int c = 0; c < BASE * 3 && done_cnt == d0; c++) begin
      @(posedge clk); #2;
      if (c < BASE - 4) begin
        bus.stall = $urandom_range(99) < pct;
        bus.start = extra && ($urandom_range(5) == 0);
        if (bus.stall) exp_busy++;
      end else begin
        bus.stall = 1'b0;
        bus.start = 1'b0;
      end
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_cnt - d0, 1);
    chk("idle_after_done", {bus.rd_en, bus.wr_en, bus.busy, bus.done}, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk("reset_outputs", {bus.stage_num, bus.r_addr_0_1, bus.r_addr_2_3, bus.w_addr_0_1, bus.w_addr_2_3,
                             bus.rd_en, bus.wr_en, bus.busy, bus.done}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      chk("idle_no_start", {bus.rd_en, bus.wr_en, bus.busy, bus.done}, 0);
      bus.stall = 1'($urandom_range(1));
    end
    bus.stall = 1'b0;
    do_run(0, 1'b0, 1'b0);
    do_run(0, 1'b0, 1'b1);
    do_run(25, 1'b1, 1'b0);
    do_run(10, 1'b1, 1'b1);
    push_model();
    exp_busy = BASE;
    @(posedge clk); #2 bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    repeat (25) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {bus.stage_num, bus.r_addr_0_1, bus.r_addr_2_3, bus.w_addr_0_1, bus.w_addr_2_3,
                           bus.rd_en, bus.wr_en, bus.busy, bus.done}, 0);
    rq.delete();
    wq.delete();
    tq.delete();
    busy_cnt = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("post_reset_idle", {bus.rd_en, bus.wr_en, bus.busy, bus.done}, 0);
    end
    do_run(15, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
